// File: rtl/ysyx_22041071_hazard_ctrl_pkg.sv
// Shared encodings for the ysyx_22041071 hazard controller: FSM states,
// forwarding select codes and the scoreboard entry layout.
package ysyx_22041071_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_MEMWAIT = 2'd3
    } state_t;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } sb_entry_t;

    function automatic logic slot_hit(input sb_entry_t s, input logic [4:0] rs);
        return s.v && (s.rd == rs);
    endfunction

    // Youngest producer wins; x0 and unused operands always read the regfile.
    function automatic logic [1:0] fwd_pick(input logic [4:0] rs, input logic use_rs,
                                            input sb_entry_t ex, input sb_entry_t mem,
                                            input sb_entry_t wb);
        if (!use_rs || rs == 5'd0) return FWD_REG;
        if (slot_hit(ex, rs))      return FWD_EX;
        if (slot_hit(mem, rs))     return FWD_MEM;
        if (slot_hit(wb, rs))      return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/ysyx_22041071_sb_slot.sv
// One scoreboard entry: advances from its predecessor unless the pipe is
// frozen; only the valid bit is cleared by reset.
module ysyx_22041071_sb_slot
    import ysyx_22041071_hazard_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      advance,
    input  sb_entry_t d,
    output sb_entry_t q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q.v <= 1'b0;
        end else if (advance) begin
            q.v <= d.v;
        end
        if (advance) begin
            q.rd <= d.rd;
            q.ld <= d.ld;
        end
    end

endmodule

// File: rtl/ysyx_22041071_hazard_ctrl.sv
// Pipeline hazard controller: scoreboard-based forwarding, load-use stall,
// redirect flush, memory-wait freeze and saturating stall/flush counters.
module ysyx_22041071_hazard_ctrl
    import ysyx_22041071_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_ready,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic             flush_id,
    output logic             freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t    state_q;
    state_t    state_d;
    sb_entry_t sb_ex;
    sb_entry_t sb_mem;
    sb_entry_t sb_wb;
    sb_entry_t ex_d;
    logic      load_use;
    logic      issue;
    logic      advance;

    assign load_use = id_valid &&
        ((id_use_rs1 && id_rs1 != 5'd0 && sb_ex.ld && slot_hit(sb_ex, id_rs1)) ||
         (id_use_rs2 && id_rs2 != 5'd0 && sb_ex.ld && slot_hit(sb_ex, id_rs2)));

    assign issue   = id_valid && !stall_id && !flush_id && !freeze;
    assign advance = !freeze;

    assign ex_d.v  = issue && id_wen && (id_rd != 5'd0);
    assign ex_d.rd = id_rd;
    assign ex_d.ld = id_is_load;

    ysyx_22041071_sb_slot u_sb_ex (
        .clk(clk), .reset(reset), .advance(advance), .d(ex_d), .q(sb_ex)
    );
    ysyx_22041071_sb_slot u_sb_mem (
        .clk(clk), .reset(reset), .advance(advance), .d(sb_ex), .q(sb_mem)
    );
    ysyx_22041071_sb_slot u_sb_wb (
        .clk(clk), .reset(reset), .advance(advance), .d(sb_mem), .q(sb_wb)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // MEMWAIT and LDSTALL resolve exactly like RUN; only FLUSH differs.
    always_comb begin
        state_d   = state_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        freeze    = 1'b0;
        fwd_sel1  = fwd_pick(id_rs1, id_use_rs1, sb_ex, sb_mem, sb_wb);
        fwd_sel2  = fwd_pick(id_rs2, id_use_rs2, sb_ex, sb_mem, sb_wb);
        state     = state_q;
        case (state_q)
            ST_FLUSH: begin
                flush_if = 1'b1;
                if (!mem_ready) begin
                    freeze   = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    state_d  = ST_MEMWAIT;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = ST_LDSTALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (!mem_ready) begin
                    freeze   = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    state_d  = ST_MEMWAIT;
                end else if (ex_redirect) begin
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = ST_FLUSH;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    state_d   = ST_LDSTALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
        if (reset) begin
            state_d   = ST_RUN;
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            bubble_ex = 1'b0;
            flush_if  = 1'b0;
            flush_id  = 1'b0;
            freeze    = 1'b0;
            fwd_sel1  = FWD_REG;
            fwd_sel2  = FWD_REG;
            state     = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_stall <= '0;
            cnt_flush <= '0;
        end else begin
            if (stall_id && cnt_stall != '1) cnt_stall <= cnt_stall + CNT_ONE;
            if (flush_id && cnt_flush != '1) cnt_flush <= cnt_flush + CNT_ONE;
        end
    end

endmodule

// File: doc/ysyx_22041071_hazard_ctrl.md
# ysyx_22041071_hazard_ctrl

Central pipeline hazard and sequencing controller for the ysyx_22041071 five-stage RV64 core. It keeps a scoreboard of in-flight destination registers for EX/MEM/WB and drives the operand forwarding selects used by ID. It also generates the load-use stall, branch/jalr redirect flush, and memory-wait freeze signals that sequence IF/ID/EX/MEM/WB. Saturating performance counters record stall and flush cycles.

## Interface
- CNT_W, 32, width of performance counters
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- id_rs1, id_rs2  in  5 each  ID source register indices
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2
- id_rd  in  5  ID destination index
- id_wen  in  1  ID instruction writes a register
- id_is_load  in  1  ID instruction is a load (opcode 0000011)
- ex_redirect  in  1  EX resolved a taken branch or jalr this cycle
- mem_ready  in  1  data memory completes/accepts this cycle
- fwd_sel1, fwd_sel2  out  2 each  0 regfile, 1 EX result, 2 MEM WB_data, 3 WB data
- stall_if, stall_id  out  1 each  hold PC / IF-ID register
- bubble_ex  out  1  load NOP into ID/EX register
- flush_if, flush_id  out  1 each  invalidate IF / ID contents
- freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
- state  out  2  FSM state (debug)
- cnt_stall, cnt_flush  out  CNT_W each  saturating event counters

## Operation
- Scoreboard: three slots SB_EX, SB_MEM, SB_WB, each {v, rd[4:0], ld}.
- Issue = id_valid & !stall_id & !flush_id & !freeze. On every non-freeze edge, SB_EX loads {issue & id_wen & id_rd!=0, id_rd, id_is_load}, SB_MEM loads SB_EX, and SB_WB loads SB_MEM. Freeze holds all three slots.
- Forwarding, per operand N. If rsN==0 or !id_use_rsN, sel=0. Otherwise the first hit in priority order SB_EX(1) > SB_MEM(2) > SB_WB(3) wins, else 0.
- Load-use condition: id_valid & id_use_rsN & SB_EX.v & SB_EX.ld & SB_EX.rd==rsN & rsN!=0.
- Condition priority: !mem_ready (freeze) > ex_redirect > load-use.
- FSM states are RUN=0, LDSTALL=1, FLUSH=2, MEMWAIT=3.
  - RUN/LDSTALL:
    - !mem_ready: freeze=stall_if=stall_id=1, next state MEMWAIT.
    - Else ex_redirect: flush_if=flush_id=bubble_ex=1, next state FLUSH.
    - Else load-use: stall_if=stall_id=bubble_ex=1, next state LDSTALL.
    - Else no action, next state RUN.
  - FLUSH: flush_if=1, because the fetch issued in the redirect cycle belongs to the stale PC. Load-use and freeze are evaluated as in RUN. Next state RUN, or MEMWAIT if !mem_ready.
  - MEMWAIT: freeze=stall_if=stall_id=1 while mem_ready=0. An ex_redirect held in the frozen EX stage is not acted on. On mem_ready=1, the state evaluates exactly as RUN in the same cycle, so a pending redirect is taken then.
- Counters:
  - cnt_stall increments on every cycle with stall_id=1.
  - cnt_flush increments on every cycle with flush_id=1.
  - Both saturate at all-ones.

## Timing
- Reset:
  - state=RUN, all scoreboard v=0, counters=0.
  - While reset is high, every control output is forced to 0, including fwd_sel=0, freeze=0 and state=0, regardless of mem_ready.
- Forward selects, stall, flush and freeze are combinational from the current state, scoreboard and inputs, with zero latency in the cycle the hazard is visible in ID.
- Load-use costs exactly 1 bubble. In the following cycle the load sits in SB_MEM, and the consumer gets fwd_sel=2.
- Redirect costs 2 cycles of flush_if and 1 cycle of flush_id.
- A redirect and a load-use in the same cycle: redirect wins, and the stall is not applied because the ID instruction is discarded.
- rd==0 is never recorded, so x0 is never forwarded.
- Reset asserted mid-MEMWAIT or mid-FLUSH returns to RUN on the next edge.

## Structure
- Shared package/define file holds:
  - FSM state encodings (RUN/LDSTALL/FLUSH/MEMWAIT),
  - forward-select codes (FWD_REG/EX/MEM/WB),
  - LOAD opcode constant 7'b0000011.
- Natural sub-module: ysyx_22041071_sb_slot, one pipeline scoreboard entry with its hold/advance logic, instantiated three times.
- Counters and FSM stay in the top module.

## Test plan
- Back-to-back ALU ops: addi x5 then add x6,x5,x5 → fwd_sel1=fwd_sel2=1, no stall, cnt_stall=0.
- ld x7 then add x8,x7,x0 → one cycle stall_if=stall_id=bubble_ex=1 with state→LDSTALL, then fwd_sel1=2 and cnt_stall=1.
- x5 written by three consecutive instructions (EX, MEM, WB all hold x5), consumer reads x5 → fwd_sel1=1 (EX priority). Writes to x0 → fwd_sel=0.
- ex_redirect pulse for 1 cycle → flush_if high 2 cycles, flush_id and bubble_ex high 1 cycle, state RUN→FLUSH→RUN, cnt_flush=1.
- mem_ready=0 for 4 cycles with ex_redirect=1 throughout → freeze high 4 cycles, scoreboard unchanged, no flush. On mem_ready=1 → flush_id=1 and state→FLUSH. cnt_stall=4 (no stall_id in the redirect cycle).
- Reset asserted during MEMWAIT with mem_ready=0 → all outputs 0 in that cycle, state=RUN and counters=0 after the edge.
